// File: rtl/barcodescanner_nios_scan_pkg.sv
//----------------------------------------------------------------------
// barcodescanner_nios_scan_pkg: register map, bit indices, FSM states
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

package barcodescanner_nios_scan_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_TERM   = 2'd3;

  localparam int STAT_EMPTY = 9;
  localparam int STAT_FULL  = 10;
  localparam int STAT_OVF   = 11;
  localparam int STAT_TERM  = 12;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IRQEN = 1;
  localparam int CTRL_FLUSH = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_PUSH   = 2'd2
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/barcodescanner_nios_scan_ctrl_if.sv
//----------------------------------------------------------------------
// barcodescanner_nios_scan_ctrl_if: Avalon-MM slave bus plus interrupt
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface barcodescanner_nios_scan_ctrl_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, read, write, writedata, input readdata, irq);
  modport slave  (input address, read, write, writedata, output readdata, irq);
endinterface

`default_nettype wire

// File: rtl/barcodescanner_nios_scan_fifo.sv
//----------------------------------------------------------------------
// barcodescanner_nios_scan_fifo: sync FIFO with fall-through head and flush
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module barcodescanner_nios_scan_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  input  wire logic          push,
  input  wire logic [7:0]    push_data,
  input  wire logic          pop,
  input  wire logic          flush,
  output logic      [7:0]    head,
  output logic               full,
  output logic               empty,
  output logic      [CW-1:0] count
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/barcodescanner_nios_scan_ctrl.sv
//----------------------------------------------------------------------
// barcodescanner_nios_scan_ctrl: scanner strobe capture into FIFO, Avalon-MM access
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module barcodescanner_nios_scan_ctrl
  import barcodescanner_nios_scan_pkg::*;
#(
  parameter int         DEPTH         = 16,
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] TERM_DEFAULT  = 8'h0D
) (
  input  wire logic                 clk,
  input  wire logic                 reset_n,
  input  wire logic [7:0]           scan_data,
  input  wire logic                 scan_strobe,
  barcodescanner_nios_scan_ctrl_if.slave bus
);

  localparam int         CW          = $clog2(DEPTH) + 1;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  logic        strobe_m, strobe_s, strobe_d;
  logic [7:0]  data_m, data_s;
  logic        strobe_edge;

  scan_state_t state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [7:0]  snap, snap_nxt;
  logic        push;

  logic        enable, irq_en, overflow, term_seen;
  logic [7:0]  term_char;
  logic [31:0] readdata, rd_mux;

  logic [7:0]    head;
  logic          full, empty;
  logic [CW-1:0] count;

  logic wr_status, wr_ctrl, wr_term, rd_data, flush, ovf_set, term_hit;
  logic unused_bits;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_m <= 1'b0;
      strobe_s <= 1'b0;
      strobe_d <= 1'b0;
      data_m   <= '0;
      data_s   <= '0;
    end else begin
      strobe_m <= scan_strobe;
      strobe_s <= strobe_m;
      strobe_d <= strobe_s;
      data_m   <= scan_data;
      data_s   <= data_m;
    end
  end

  assign strobe_edge = strobe_s & ~strobe_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      snap  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      snap  <= snap_nxt;
    end
  end

  // Any change of the synchronised data restarts the settle window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = snap;
    push      = 1'b0;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (strobe_edge) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
          snap_nxt  = data_s;
        end
        ST_SETTLE: if (data_s != snap) begin
          snap_nxt = data_s;
          cnt_nxt  = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_PUSH;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
        ST_PUSH: begin
          push      = 1'b1;
          state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign wr_status = bus.write & (bus.address == ADDR_STATUS);
  assign wr_ctrl   = bus.write & (bus.address == ADDR_CTRL);
  assign wr_term   = bus.write & (bus.address == ADDR_TERM);
  assign rd_data   = bus.read  & (bus.address == ADDR_DATA);
  assign flush     = wr_ctrl & bus.writedata[CTRL_FLUSH];
  assign ovf_set   = push & full & ~rd_data;
  assign term_hit  = push & (snap == term_char);

  barcodescanner_nios_scan_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (snap),
    .pop       (rd_data),
    .flush     (flush),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // A new event wins over a same-cycle W1C so it is never lost.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      irq_en    <= 1'b0;
      overflow  <= 1'b0;
      term_seen <= 1'b0;
      term_char <= TERM_DEFAULT;
    end else begin
      if (wr_ctrl) begin
        enable <= bus.writedata[CTRL_EN];
        irq_en <= bus.writedata[CTRL_IRQEN];
      end
      if (wr_term) term_char <= bus.writedata[7:0];
      if (ovf_set)                                   overflow <= 1'b1;
      else if (wr_status && bus.writedata[STAT_OVF]) overflow <= 1'b0;
      if (term_hit)                                   term_seen <= 1'b1;
      else if (wr_status && bus.writedata[STAT_TERM]) term_seen <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA:   if (!empty) rd_mux = {23'b0, 1'b1, head};
      ADDR_STATUS: begin
        rd_mux[8:0]        = 9'(count);
        rd_mux[STAT_EMPTY] = empty;
        rd_mux[STAT_FULL]  = full;
        rd_mux[STAT_OVF]   = overflow;
        rd_mux[STAT_TERM]  = term_seen;
      end
      ADDR_CTRL:   rd_mux[1:0] = {irq_en, enable};
      ADDR_TERM:   rd_mux[7:0] = term_char;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n)      readdata <= '0;
    else if (bus.read) readdata <= rd_mux;
  end

  assign bus.readdata = readdata;
  assign bus.irq      = irq_en & term_seen;
  assign unused_bits  = ^{bus.writedata[31:13], bus.writedata[10:8]};

endmodule

`default_nettype wire

// File: tb/tb_barcodescanner_nios_scan_ctrl.sv
//----------------------------------------------------------------------
// tb_barcodescanner_nios_scan_ctrl: scoreboard bench for the scan controller
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_barcodescanner_nios_scan_ctrl;

  localparam logic [1:0] A_DATA = 2'd0, A_STAT = 2'd1, A_CTRL = 2'd2, A_TERM = 2'd3;
  localparam int FDEPTH = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] scan_data;
  logic       scan_strobe;

  barcodescanner_nios_scan_ctrl_if bus ();

  barcodescanner_nios_scan_ctrl dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .scan_data   (scan_data),
    .scan_strobe (scan_strobe),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] exp_q[$];
  logic       m_en, m_irqen, m_term, m_ovf;
  logic [7:0] m_termchar;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    tick(1);
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a; bus.read = 1'b1;
    tick(1);
    bus.read = 1'b0;
    d = bus.readdata;
  endtask

  function automatic logic [31:0] exp_status();
    int n = exp_q.size();
    return {19'b0, m_term, m_ovf, (n == FDEPTH), (n == 0), 9'(n)};
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_en = 1'b0; m_irqen = 1'b0; m_term = 1'b0; m_ovf = 1'b0; m_termchar = 8'h0D;
  endtask

  task automatic model_push(input logic [7:0] c);
    if (m_en) begin
      if (exp_q.size() < FDEPTH) exp_q.push_back(c);
      else m_ovf = 1'b1;
      if (c == m_termchar) m_term = 1'b1;
    end
  endtask

  task automatic model_ctrl(input logic [31:0] d);
    m_en = d[0]; m_irqen = d[1];
    if (d[2]) exp_q.delete();
  endtask

  task automatic read_data_check(input string tag);
    logic [31:0] d, e;
    e = '0;
    bus_read(A_DATA, d);
    if (exp_q.size() > 0) e = {23'b0, 1'b1, exp_q.pop_front()};
    check(tag, d, e);
  endtask

  task automatic check_status(input string tag);
    logic [31:0] d;
    bus_read(A_STAT, d);
    check(tag, d, exp_status());
  endtask

  task automatic check_irq(input string tag);
    check(tag, {31'b0, bus.irq}, {31'b0, m_term & m_irqen});
  endtask

  task automatic send_char(input logic [7:0] c);
    scan_data = c; scan_strobe = 1'b1;
    tick(8);
    scan_strobe = 1'b0;
    tick(3);
    model_push(c);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    reset_n = 1'b0; scan_data = '0; scan_strobe = 1'b0;
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    model_reset();
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset in the middle of a settle window
    bus_read(A_TERM, d);
    check("term_default", d, 32'h0D);
    bus_write(A_CTRL, 32'h1);
    scan_data = 8'h55; scan_strobe = 1'b1;
    tick(4);
    reset_n = 1'b0; scan_strobe = 1'b0;
    tick(1);
    reset_n = 1'b1;
    model_reset();
    check("reset_readdata", bus.readdata, 32'h0);
    check_irq("reset_irq");
    tick(10);
    check_status("reset_status");
    bus_read(A_TERM, d);
    check("reset_term", d, 32'h0D);
    bus_read(A_CTRL, d);
    check("reset_ctrl", d, 32'h0);

    // Single capture with exact latency
    bus_write(A_CTRL, 32'h1); model_ctrl(32'h1);
    scan_data = 8'h41; scan_strobe = 1'b1;
    tick(7);
    check_status("cap_before");
    model_push(8'h41);
    check_status("cap_after");
    scan_strobe = 1'b0;
    tick(3);
    read_data_check("cap_data");
    read_data_check("cap_empty_data");
    check_status("cap_empty_status");

    // Terminator raises the interrupt
    bus_write(A_CTRL, 32'h3); model_ctrl(32'h3);
    send_char(8'h41);
    send_char(8'h42);
    check_irq("term_irq_low");
    send_char(8'h0D);
    check_irq("term_irq_high");
    check_status("term_status");
    bus_write(A_STAT, 32'h1000); m_term = 1'b0;
    check_irq("term_irq_clr");
    for (int i = 0; i < 3; i++) read_data_check("term_drain");

    // Overflow with 17 characters
    bus_write(A_CTRL, 32'h1); model_ctrl(32'h1);
    for (int i = 0; i < 17; i++) send_char(8'h60 + 8'(i));
    check_status("ovf_status");
    for (int i = 0; i < 16; i++) read_data_check("ovf_drain");
    bus_write(A_STAT, 32'h800); m_ovf = 1'b0;
    check_status("ovf_cleared");

    // Data change during the settle window restarts it
    scan_data = 8'h30; scan_strobe = 1'b1;
    tick(4);
    scan_data = 8'h31;
    tick(7);
    check_status("settle_before");
    model_push(8'h31);
    check_status("settle_after");
    scan_strobe = 1'b0;
    tick(3);
    read_data_check("settle_data");
    read_data_check("settle_single");

    // Push and pop in the same cycle while full
    for (int i = 0; i < 16; i++) send_char(8'h80 + 8'(i));
    check_status("pp_full");
    scan_data = 8'h7F; scan_strobe = 1'b1;
    tick(7);
    read_data_check("pp_pop");
    model_push(8'h7F);
    scan_strobe = 1'b0;
    tick(3);
    check_status("pp_status");

    // Flush beats a same-cycle push
    read_data_check("fl_pre_pop");
    scan_data = 8'h33; scan_strobe = 1'b1;
    tick(7);
    bus_write(A_CTRL, 32'h5); model_ctrl(32'h5);
    scan_strobe = 1'b0;
    tick(3);
    check_status("fl_status");
    bus_read(A_CTRL, d);
    check("fl_ctrl_read", d, 32'h1);
    send_char(8'h22);
    read_data_check("fl_after");

    // Programmable terminator and disable discard
    bus_write(A_CTRL, 32'h3); model_ctrl(32'h3);
    bus_write(A_TERM, 32'h2A); m_termchar = 8'h2A;
    bus_read(A_TERM, d);
    check("term_prog", d, 32'h2A);
    send_char(8'h0D);
    check_irq("term_old_no_irq");
    send_char(8'h2A);
    check_irq("term_new_irq");
    bus_write(A_CTRL, 32'h0); model_ctrl(32'h0);
    check_irq("irq_masked");
    send_char(8'h44);
    check_status("dis_status");
    read_data_check("dis_drain0");
    read_data_check("dis_drain1");
    read_data_check("dis_empty");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
